// File: rtl/sdram_pkg.sv
// Shared types and default widths for the SDRAM Wishbone front end
// (arbiter and controller).
package sdram_pkg;

    // Default bus widths, shared with sdram_wb_controller
    localparam int SDRAM_AW = 24;
    localparam int SDRAM_DW = 16;

    // Arbiter transfer state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Arbitration policy
    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/sdram_wb_arbiter_pick.sv
// Combinational winner selection. Round-robin starts searching one past
// the previous winner; fixed priority always starts at port 0.
module rr_arbiter_pick
    import sdram_pkg::*;
#(
    parameter  int NPORTS = 4,
    localparam int IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last_g,
    input  arb_mode_e         mode,
    output logic [NPORTS-1:0] grant,
    output logic              valid
);

    int            sum;
    logic [IW-1:0] idx;

    // Walk the ports in search order and keep the first requester found
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (mode == ARB_FIXED) begin
                sum = i;
            end else begin
                sum = int'(last_g) + 1 + i;
                if (sum >= NPORTS) begin
                    sum = sum - NPORTS;
                end
            end
            idx = IW'(sum);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// N-port Wishbone arbiter in front of the SDRAM controller. One classic
// single-beat cycle is forwarded at a time; the winner may keep the grant
// for up to MAX_HOLD back-to-back cycles.
module sdram_wb_arbiter
    import sdram_pkg::*;
#(
    parameter int NPORTS   = 4,
    parameter int AW       = SDRAM_AW,
    parameter int DW       = SDRAM_DW,
    parameter int SW       = DW / 8,
    parameter int ARB_MODE = 0,
    parameter int MAX_HOLD = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NPORTS-1:0]    s_cyc_i,
    input  logic [NPORTS-1:0]    s_stb_i,
    input  logic [NPORTS-1:0]    s_we_i,
    input  logic [NPORTS*AW-1:0] s_adr_i,
    input  logic [NPORTS*DW-1:0] s_dat_i,
    input  logic [NPORTS*SW-1:0] s_sel_i,
    output logic [NPORTS-1:0]    s_ack_o,
    output logic [DW-1:0]        s_dat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [AW-1:0]        m_adr_o,
    output logic [DW-1:0]        m_dat_o,
    output logic [SW-1:0]        m_sel_o,
    input  logic                 m_ack_i,
    input  logic [DW-1:0]        m_dat_i,
    output logic [NPORTS-1:0]    grant_o,
    output logic                 busy_o
);

    localparam int                IW       = $clog2(NPORTS);
    localparam int                HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]     HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [NPORTS-1:0] ONE      = NPORTS'(1);
    localparam arb_mode_e         MODE     = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IW-1:0]     last_g_q;
    logic [HW-1:0]     hold_cnt_q;
    logic              abort_q;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] pick_grant;
    logic              pick_valid;
    logic              hold_win;
    logic [NPORTS-1:0] win_oh;
    logic              win_valid;
    logic [IW-1:0]     win_idx;
    logic              cur_cyc;

    logic              do_grant;
    logic              do_capture;
    logic              do_release;
    logic              ack_ok;

    assign req      = s_cyc_i & s_stb_i;
    assign cur_cyc  = s_cyc_i[last_g_q];
    assign hold_win = (hold_cnt_q != '0) && req[last_g_q] && (hold_cnt_q < HOLD_MAX);
    assign win_oh   = hold_win ? (ONE << last_g_q) : pick_grant;
    assign win_valid = hold_win | pick_valid;
    assign busy_o   = (state_q != IDLE);

    rr_arbiter_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .req    (req),
        .last_g (last_g_q),
        .mode   (MODE),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    // Convert the one-hot winner to an index for the request mux
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (win_oh[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ACK always falls back to IDLE so stale strobes are never seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ISSUE;
            ISSUE:   if (m_ack_i)   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state control strobes; an ack is only returned if the owner never dropped cyc
    always_comb begin
        do_grant   = (state_q == IDLE) && win_valid;
        do_capture = (state_q == ISSUE) && m_ack_i;
        do_release = (state_q == ACK);
        ack_ok     = !abort_q && cur_cyc;
    end

    // Registered downstream request, read data, ack pulse and grant
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
            s_dat_o <= '0;
            s_ack_o <= '0;
            grant_o <= '0;
        end else begin
            s_ack_o <= '0;
            if (do_grant) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= s_we_i[win_idx];
                m_adr_o <= s_adr_i[int'(win_idx) * AW +: AW];
                m_dat_o <= s_dat_i[int'(win_idx) * DW +: DW];
                m_sel_o <= s_sel_i[int'(win_idx) * SW +: SW];
                grant_o <= win_oh;
            end
            if (do_capture) begin
                m_cyc_o <= 1'b0;
                m_stb_o <= 1'b0;
                s_dat_o <= m_dat_i;
                if (ack_ok) begin
                    s_ack_o <= grant_o;
                end
            end
            if (do_release) begin
                grant_o <= '0;
            end
        end
    end

    // Owner pointer, hold counter and abort tracking
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            last_g_q   <= IW'(NPORTS - 1);
            hold_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            if (do_grant) begin
                last_g_q   <= win_idx;
                hold_cnt_q <= hold_win ? (hold_cnt_q + HW'(1)) : HW'(1);
                abort_q    <= 1'b0;
            end else if ((state_q == IDLE) && !cur_cyc) begin
                hold_cnt_q <= '0;
            end
            if ((state_q == ISSUE) && !cur_cyc) begin
                abort_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter. Three instances cover hold/round-robin
// (k=0), pure round-robin (k=1) and fixed priority (k=2).
module tb_sdram_wb_arbiter;

    logic clk;
    logic rst_n;

    logic [3:0]  cyc   [3];
    logic [3:0]  stb   [3];
    logic [3:0]  we    [3];
    logic [95:0] adr   [3];
    logic [63:0] dat   [3];
    logic [7:0]  sel   [3];
    logic [3:0]  sack  [3];
    logic [15:0] sdat  [3];
    logic        mcyc  [3];
    logic        mstb  [3];
    logic        mwe   [3];
    logic [23:0] madr  [3];
    logic [15:0] mdat  [3];
    logic [1:0]  msel  [3];
    logic        mack  [3];
    logic [15:0] mdati [3];
    logic [3:0]  grant [3];
    logic        busy  [3];

    logic [15:0] mem [logic [23:0]];

    int compared   = 0;
    int mismatched = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sdram_wb_arbiter #(
            .NPORTS   (4),
            .AW       (24),
            .DW       (16),
            .ARB_MODE ((k == 2) ? 1 : 0),
            .MAX_HOLD ((k == 0) ? 4 : 1)
        ) dut (
            .wb_clk_i   (clk),
            .wb_rst_n_i (rst_n),
            .s_cyc_i    (cyc[k]),
            .s_stb_i    (stb[k]),
            .s_we_i     (we[k]),
            .s_adr_i    (adr[k]),
            .s_dat_i    (dat[k]),
            .s_sel_i    (sel[k]),
            .s_ack_o    (sack[k]),
            .s_dat_o    (sdat[k]),
            .m_cyc_o    (mcyc[k]),
            .m_stb_o    (mstb[k]),
            .m_we_o     (mwe[k]),
            .m_adr_o    (madr[k]),
            .m_dat_o    (mdat[k]),
            .m_sel_o    (msel[k]),
            .m_ack_i    (mack[k]),
            .m_dat_i    (mdati[k]),
            .grant_o    (grant[k]),
            .busy_o     (busy[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input int p, input logic w, input logic [23:0] a,
                                 input logic [15:0] d, input logic [1:0] s);
        cyc[k][p] = 1'b1;
        stb[k][p] = 1'b1;
        we[k][p]  = w;
        adr[k][p*24 +: 24] = a;
        dat[k][p*16 +: 16] = d;
        sel[k][p*2 +: 2]   = s;
    endtask

    task automatic release_port(input int k, input int p);
        cyc[k][p] = 1'b0;
        stb[k][p] = 1'b0;
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int n = 0;
        int r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] === 1'b1) begin
                n++;
                r = i;
            end
        end
        return (n == 1) ? r : -1;
    endfunction

    // Downstream memory model: waits for the request, acks after 'delay' cycles,
    // returns in the ACK-state negedge. abort_p >= 0 drops that port's cyc in ISSUE.
    task automatic serve(input int k, input int delay, input int abort_p,
                         output int g, output int lat, output logic [15:0] rd);
        int n;
        logic [15:0] old;
        n  = 0;
        rd = '0;
        while (mstb[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        g   = -1;
        if (mstb[k] !== 1'b1) begin
            checkOutput("stb_timeout", 32'd0, 32'd1);
            return;
        end
        g = oh2idx(grant[k]);
        if (abort_p >= 0) release_port(k, abort_p);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("stb_held", {31'b0, mstb[k]}, 32'd1);
        end
        if (mwe[k]) begin
            old = mem.exists(madr[k]) ? mem[madr[k]] : 16'h0000;
            mem[madr[k]] = {msel[k][1] ? mdat[k][15:8] : old[15:8],
                            msel[k][0] ? mdat[k][7:0]  : old[7:0]};
        end else begin
            rd = mem.exists(madr[k]) ? mem[madr[k]] : (16'hA5A5 ^ madr[k][15:0]);
        end
        mdati[k] = rd;
        mack[k]  = 1'b1;
        @(negedge clk);
        mack[k]  = 1'b0;
    endtask

    int          g;
    int          lat;
    logic [15:0] rd;
    logic [3:0]  exp_ack;
    int          hold_exp [7] = '{3, 3, 3, 3, 0, 3, 3};

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = '0; stb[k] = '0; we[k] = '0; adr[k] = '0; dat[k] = '0; sel[k] = '0;
            mack[k] = 1'b0; mdati[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_grant", {28'b0, grant[k]}, 32'd0);
            checkOutput("reset_busy",  {31'b0, busy[k]},  32'd0);
            checkOutput("reset_mcyc",  {31'b0, mcyc[k]},  32'd0);
            checkOutput("reset_sack",  {28'b0, sack[k]},  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single port: write then read back through port 1
        applyStimulus(0, 1, 1'b1, 24'h000010, 16'hBEEF, 2'b11);
        serve(0, 0, -1, g, lat, rd);
        checkOutput("sp_wr_grant",   g, 32'd1);
        checkOutput("sp_latency",    lat, 32'd1);
        checkOutput("sp_wr_adr",     {8'b0, madr[0]}, 32'h10);
        checkOutput("sp_wr_dat",     {16'b0, mdat[0]}, 32'hBEEF);
        checkOutput("sp_wr_we",      {31'b0, mwe[0]}, 32'd1);
        checkOutput("sp_wr_ack",     {28'b0, sack[0]}, 32'b0010);
        release_port(0, 1);
        @(negedge clk);
        checkOutput("sp_wr_ack_once", {28'b0, sack[0]}, 32'd0);
        checkOutput("sp_idle_busy",   {31'b0, busy[0]}, 32'd0);
        applyStimulus(0, 1, 1'b0, 24'h000010, 16'h0000, 2'b11);
        serve(0, 0, -1, g, lat, rd);
        checkOutput("sp_rd_grant", g, 32'd1);
        checkOutput("sp_rd_ack",   {28'b0, sack[0]}, 32'b0010);
        checkOutput("sp_rd_data",  {16'b0, sdat[0]}, 32'hBEEF);
        release_port(0, 1);
        @(negedge clk);
        checkOutput("sp_rd_ack_once", {28'b0, sack[0]}, 32'd0);

        // Hold: port 3 streams reads while port 0 wants one transfer
        applyStimulus(0, 3, 1'b0, 24'h000030, 16'h0000, 2'b11);
        applyStimulus(0, 0, 1'b0, 24'h000040, 16'h0000, 2'b11);
        for (int i = 0; i < 7; i++) begin
            serve(0, 0, -1, g, lat, rd);
            exp_ack = 4'(1 << hold_exp[i]);
            checkOutput("hold_grant", g, hold_exp[i]);
            checkOutput("hold_ack",   {28'b0, sack[0]}, {28'b0, exp_ack});
            checkOutput("hold_rdata", {16'b0, sdat[0]}, {16'b0, rd});
            if (hold_exp[i] == 0) release_port(0, 0);
        end
        release_port(0, 3);
        @(negedge clk);

        // Abort: port 2 drops cyc while the downstream ack is 5 cycles away
        applyStimulus(0, 2, 1'b1, 24'h000020, 16'h1234, 2'b01);
        serve(0, 5, 2, g, lat, rd);
        checkOutput("abort_grant",    g, 32'd2);
        checkOutput("abort_no_ack",   {28'b0, sack[0]}, 32'd0);
        checkOutput("abort_stb_drop", {31'b0, mstb[0]}, 32'd0);
        checkOutput("abort_ack_busy", {31'b0, busy[0]}, 32'd1);
        @(negedge clk);
        checkOutput("abort_idle_busy",  {31'b0, busy[0]}, 32'd0);
        checkOutput("abort_idle_grant", {28'b0, grant[0]}, 32'd0);
        checkOutput("abort_idle_sack",  {28'b0, sack[0]}, 32'd0);

        // Reset asserted in the middle of ISSUE
        applyStimulus(0, 1, 1'b1, 24'h000050, 16'h5555, 2'b11);
        @(negedge clk);
        checkOutput("rst_in_issue", {31'b0, mstb[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_mcyc",  {31'b0, mcyc[0]}, 32'd0);
        checkOutput("rst_async_grant", {28'b0, grant[0]}, 32'd0);
        checkOutput("rst_async_busy",  {31'b0, busy[0]}, 32'd0);
        release_port(0, 1);
        applyStimulus(0, 0, 1'b0, 24'h000060, 16'h0000, 2'b11);
        applyStimulus(0, 3, 1'b0, 24'h000070, 16'h0000, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 0, -1, g, lat, rd);
        checkOutput("rst_first_grant", g, 32'd0);
        checkOutput("rst_first_ack",   {28'b0, sack[0]}, 32'b0001);
        release_port(0, 0);
        serve(0, 0, -1, g, lat, rd);
        checkOutput("rst_second_grant", g, 32'd3);
        release_port(0, 3);
        @(negedge clk);

        // Round-robin with hold disabled, all four ports requesting
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1, p, 1'b0, 24'h000100 + 24'(p), 16'h0000, 2'b11);
        end
        for (int i = 0; i < 8; i++) begin
            serve(1, 0, -1, g, lat, rd);
            exp_ack = 4'(1 << (i % 4));
            checkOutput("rr_grant", g, i % 4);
            checkOutput("rr_ack",   {28'b0, sack[1]}, {28'b0, exp_ack});
        end
        for (int p = 0; p < 4; p++) release_port(1, p);
        @(negedge clk);

        // Fixed priority: port 0 starves port 2 until it drops cyc
        applyStimulus(2, 0, 1'b0, 24'h000200, 16'h0000, 2'b11);
        applyStimulus(2, 2, 1'b0, 24'h000202, 16'h0000, 2'b11);
        for (int i = 0; i < 3; i++) begin
            serve(2, 0, -1, g, lat, rd);
            checkOutput("fx_grant_p0", g, 32'd0);
            checkOutput("fx_ack_p0",   {28'b0, sack[2]}, 32'b0001);
        end
        release_port(2, 0);
        for (int i = 0; i < 2; i++) begin
            serve(2, 0, -1, g, lat, rd);
            checkOutput("fx_grant_p2", g, 32'd2);
            checkOutput("fx_ack_p2",   {28'b0, sack[2]}, 32'b0100);
        end
        release_port(2, 2);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
